uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the MCU's single UART transmitter between NUM_REQ byte-stream requesters, e.g. CPU MMIO store path and a debug/trace source.
- Round-robin arbitration with packet lock: a granted requester keeps the UART until it sends a byte flagged last, or until it idles past a timeout.
- Sits between the requesters and the uart_tx core that drives uart_tx_pin; sequences that core through a start/busy handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, owner-idle cycles before forced release; 0 disables the timeout.
- TO_W, 13, width of the idle-timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte ends requester's packet.
- req_ready  out  NUM_REQ  byte accepted this cycle when valid&ready.
- grant  out  NUM_REQ  one-hot current owner; 0 when unowned.
- tx_start  out  1  one-cycle pulse to uart_tx core.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls.
- tx_busy  in  1  uart_tx core busy; rises the cycle after tx_start, falls after the stop bit.
- timeout_pulse  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: req_ready=0, grant=0, tx_start=0, tx_data=0, timeout_pulse=0.
  - State: FSM=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first; timeout counter=0.
  - An in-flight byte is abandoned; the uart_tx core is reset by the same rst.
- IDLE: if any req_valid, select the first valid index after rr_ptr (modulo NUM_REQ). Register the owner, set grant, go to OWN. Arbitration takes 1 cycle.
- OWN:
  - req_ready[owner] = req_valid[owner] & ~tx_busy (combinational). All other req_ready bits are 0.
  - On transfer: tx_data<=byte, tx_start<=1 next cycle, last_flag<=req_last[owner], go to WAIT_BUSY.
  - If req_valid[owner]=0, the timeout counter increments. It clears on any transfer.
  - Timeout: at count==TIMEOUT_CYCLES (if nonzero), grant<=0, rr_ptr<=owner, timeout_pulse=1 for 1 cycle, go to IDLE.
- WAIT_BUSY: tx_start=0. Wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0.
  - If last_flag: rr_ptr<=owner, grant<=0, go to IDLE.
  - Otherwise go to OWN.
- Latency: byte accepted to tx_start is 1 cycle. Release to the next grant is 1 cycle (IDLE arbitration).
- Non-owner requests are never accepted while a packet is open, and they do not preempt it.
- A single-byte packet (last on the first byte) releases after that byte.
- Fairness:
  - With all requesters valid, grants rotate 0,1,..,NUM_REQ-1,0.
  - A lone requester is re-granted back-to-back.
- tx_busy high in IDLE or OWN (e.g. after a prior reset): no transfer until it clears.
- req_data of non-owners is ignored. An owner changing data while valid&~ready is tolerated; the accepted value is the one sampled on the transfer cycle.

Optional Feature:
- Macro: UART_TX_ARBITER_STATS_EN.
- When defined:
  - Adds output bytes_sent [16*NUM_REQ-1:0], a per-requester byte count that increments on each transfer and wraps at 16 bits.
  - Adds output timeouts [7:0], a total forced-release count that saturates at 255.
  - All counters clear on rst.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Single packet: req0 sends 'H'(0x48) without last, then 'i'(0x69) with last. Required: tx_data 0x48 then 0x69, each with one tx_start pulse; grant=01 throughout; grant=00 after the second tx_busy fall.
- Contention: req0 and req1 both valid from reset, each sending a 2-byte packet. Required order: req0 both bytes, then req1 both bytes; req1's req_ready stays 0 during req0's packet.
- Round-robin: both requesters continuously send 1-byte packets 0xA0/0xB0. Required tx_data sequence: A0,B0,A0,B0.
- Timeout: TIMEOUT_CYCLES=16; req1 sends one byte without last, then drops valid. Required: timeout_pulse exactly 16 cycles after tx_busy falls, grant=00, then a pending req0 is granted next cycle.
- Reset mid-byte: assert rst during WAIT_DONE. Required: all outputs 0 immediately (asynchronous); after release, req0 has priority over a simultaneous req1.
- Stats (macro defined): 3 bytes from req0 and 2 from req1. Required: bytes_sent = {16'd2, 16'd3}, timeouts=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx core between NUM_REQ byte streams, with packet lock
// and idle timeout. Optional per-requester statistics under UART_TX_ARBITER_STATS_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   timeout_pulse
`ifdef UART_TX_ARBITER_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  bytes_sent,
  output logic [7:0]             timeouts
`endif
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StOwn      = 2'd1;
  localparam logic [1:0] StWaitBusy = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic               timeout_q, timeout_d;

  logic [IW-1:0] pick, cand;
  logic          any_valid, own_valid, xfer, to_hit;

  // Walk from farthest to nearest so the first valid index after rr_ptr wins.
  always_comb begin
    pick      = rr_ptr_q;
    cand      = rr_ptr_q;
    any_valid = 1'b0;
    for (int i = NUM_REQ; i > 0; i--) begin
      cand = IW'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
      if (req_valid[cand]) begin
        pick      = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign own_valid = req_valid[owner_q];
  assign xfer      = (state_q == StOwn) && own_valid && !tx_busy;
  // Release on the TIMEOUT_CYCLES-th consecutive idle cycle of the owner.
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (state_q == StOwn) && !own_valid &&
                     (to_cnt_q == ToLast);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    to_cnt_d   = to_cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          to_cnt_d      = '0;
          state_d       = StOwn;
        end
      end
      StOwn: begin
        if (xfer) begin
          tx_data_d  = req_data[{owner_q, 3'b000} +: 8];
          tx_start_d = 1'b1;
          last_d     = req_last[owner_q];
          to_cnt_d   = '0;
          state_d    = StWaitBusy;
        end else if (to_hit) begin
          grant_d   = '0;
          rr_ptr_d  = owner_q;
          timeout_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = StIdle;
        end else if (!own_valid) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StWaitBusy: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_ptr_d = owner_q;
            grant_d  = '0;
            state_d  = StIdle;
          end else begin
            state_d = StOwn;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= IW'(NUM_REQ - 1);
      grant_q    <= '0;
      to_cnt_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      to_cnt_q   <= to_cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StOwn) req_ready[owner_q] = own_valid && !tx_busy;
  end

  assign grant         = grant_q;
  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign timeout_pulse = timeout_q;

`ifdef UART_TX_ARBITER_STATS_EN
  logic [16*NUM_REQ-1:0] bytes_sent_q;
  logic [7:0]            timeouts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_sent_q <= '0;
      timeouts_q   <= '0;
    end else begin
      if (xfer) begin
        bytes_sent_q[{owner_q, 4'b0000} +: 16] <= bytes_sent_q[{owner_q, 4'b0000} +: 16] + 16'd1;
      end
      if (timeout_d && (timeouts_q != 8'hFF)) timeouts_q <= timeouts_q + 8'd1;
    end
  end

  assign bytes_sent = bytes_sent_q;
  assign timeouts   = timeouts_q;
`else
  // Statistics counters are not built.
`endif

endmodule
